fifo_rd_ctrl: RTL

Read-side controller of the asynchronous FIFO; it is the read-domain counterpart that consumes the FIFO memory and the Gray write pointer produced by the write-side block. It synchronises the incoming Gray write pointer into R_CLK and maintains the binary and Gray read pointers. It derives EMPTY and a read-domain fill level. It presents data through a first-word-fall-through output register with a valid/ready handshake.

---
 rtl/fifo_rd_ctrl_pkg.sv | 17 +
 rtl/fifo_rd_ctrl_if.sv | 27 ++
 rtl/fifo_ptr_sync.sv | 17 +
 rtl/fifo_rd_ctrl.sv | 48 ++++
 4 files changed

// File: rtl/fifo_rd_ctrl_pkg.sv
// fifo_rd_ctrl_pkg: shared FIFO defaults and Gray/binary pointer conversions.
// Callers zero-extend narrower pointers to CODE_W and cast the result back down.
package fifo_rd_ctrl_pkg;
   localparam int FIFO_DATA_WIDTH  = 8;
   localparam int FIFO_ADDR_WIDTH  = 3;
   localparam int FIFO_SYNC_STAGES = 2;
   localparam int CODE_W           = 32;
   function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
      return b ^ (b >> 1);
   endfunction
   function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
      logic [CODE_W-1:0] b;
      b = g;
      for (int i = CODE_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: read-side FIFO bus.
// master = read controller: takes W_PTR_GREY, MEM_RD_DATA, RD_READY;
// drives RD_ADDR, GREY_R_PTR, RD_DATA, RD_VALID, EMPTY, RD_LEVEL. slave = its environment.
interface fifo_rd_ctrl_if
   import fifo_rd_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);
   logic [ADDR_WIDTH:0]   W_PTR_GREY;
   logic [DATA_WIDTH-1:0] MEM_RD_DATA;
   logic [ADDR_WIDTH-1:0] RD_ADDR;
   logic [ADDR_WIDTH:0]   GREY_R_PTR;
   logic [DATA_WIDTH-1:0] RD_DATA;
   logic                  RD_VALID;
   logic                  RD_READY;
   logic                  EMPTY;
   logic [ADDR_WIDTH:0]   RD_LEVEL;
   modport master (
      input  W_PTR_GREY, MEM_RD_DATA, RD_READY,
      output RD_ADDR, GREY_R_PTR, RD_DATA, RD_VALID, EMPTY, RD_LEVEL
   );
   modport slave (
      output W_PTR_GREY, MEM_RD_DATA, RD_READY,
      input  RD_ADDR, GREY_R_PTR, RD_DATA, RD_VALID, EMPTY, RD_LEVEL
   );
endinterface

// File: rtl/fifo_ptr_sync.sv
// fifo_ptr_sync: multi-flop bus synchroniser for Gray pointers crossing clock domains.
// Ports: R_CLK/R_RST destination clock and sync reset, D async input bus, Q last stage.
module fifo_ptr_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             R_CLK,
   input  logic             R_RST,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);
   logic [STAGES-1:0][WIDTH-1:0] sync;
   always_ff @(posedge R_CLK)
      if (R_RST) sync <= '0;
      else sync <= {sync[STAGES-2:0], D};
   assign Q = sync[STAGES-1];
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async FIFO read-side controller with first-word-fall-through output register.
// Ports: R_CLK read clock, R_RST sync active-high reset, bus (fifo_rd_ctrl_if.master) carrying
// the synchronised-in write pointer, memory read port, read pointer out, and valid/ready output.
module fifo_rd_ctrl
   import fifo_rd_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
   parameter int SYNC_STAGES = FIFO_SYNC_STAGES
) (
   input logic            R_CLK,
   input logic            R_RST,
   fifo_rd_ctrl_if.master bus
);
   localparam int PW = ADDR_WIDTH + 1;
   logic [PW-1:0]         r_ptr, wq, wq_bin, grey_r_ptr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid, empty, load;
   fifo_ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync (
      .R_CLK(R_CLK),
      .R_RST(R_RST),
      .D    (bus.W_PTR_GREY),
      .Q    (wq)
   );
   assign wq_bin     = PW'(gray2bin(CODE_W'(wq)));
   assign grey_r_ptr = PW'(bin2gray(CODE_W'(r_ptr)));
   assign empty      = grey_r_ptr == wq;
   // Refill the output register whenever it is free or being drained this cycle.
   assign load       = !empty && (!rd_valid || bus.RD_READY);
   always_ff @(posedge R_CLK)
      if (R_RST) begin
         r_ptr    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else if (load) begin
         r_ptr    <= r_ptr + 1'b1;
         rd_valid <= 1'b1;
         rd_data  <= bus.MEM_RD_DATA;
      end else if (rd_valid && bus.RD_READY) begin
         rd_valid <= 1'b0;
      end
   assign bus.RD_ADDR    = r_ptr[ADDR_WIDTH-1:0];
   assign bus.GREY_R_PTR = grey_r_ptr;
   assign bus.RD_DATA    = rd_data;
   assign bus.RD_VALID   = rd_valid;
   assign bus.EMPTY      = empty;
   assign bus.RD_LEVEL   = wq_bin - r_ptr;
endmodule
